// File: rtl/dz_pkg.sv
// Shared definitions for the DZ receive silo: RBUF field layout, size defaults
// and the scanner state encoding.
package dz_pkg;

  localparam int DZ_DEPTH_DEF = 64;
  localparam int DZ_ALARM_DEF = 16;

  localparam int RB_W        = 16;
  localparam int RB_VALID    = 15;
  localparam int RB_OVRE     = 14;
  localparam int RB_FRME     = 13;
  localparam int RB_PARE     = 12;
  localparam int RB_LINE_LSB = 8;
  localparam int RB_CHAR_LSB = 0;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_e;

  function automatic logic [RB_W-1:0] rbuf_pack(input logic ovre, input logic frme,
                                                input logic pare, input logic [2:0] line,
                                                input logic [7:0] ch);
    logic [RB_W-1:0] e;
    e                       = '0;
    e[RB_VALID]             = 1'b1;
    e[RB_OVRE]              = ovre;
    e[RB_FRME]              = frme;
    e[RB_PARE]              = pare;
    e[RB_LINE_LSB +: 3]     = line;
    e[RB_CHAR_LSB +: 8]     = ch;
    return e;
  endfunction

endpackage

// File: rtl/dz_silo_fifo.sv
// Synchronous FIFO backing the receive silo; asynchronous head read so the
// storage maps onto distributed RAM.
module dz_silo_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop on the same edge frees the slot, so a push at full still lands.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dz_rx_silo.sv
// DZ receive path: scans eight line UARTs, captures characters with their
// error flags into the silo, and raises the silo alarm after ALARM writes.
module dz_rx_silo
  import dz_pkg::*;
#(
  parameter int DEPTH = DZ_DEPTH_DEF,
  parameter int ALARM = DZ_ALARM_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            scen,
  input  logic [7:0]      rxfull,
  input  logic [63:0]     rxdata,
  input  logic [7:0]      rxpare,
  input  logic [7:0]      rxfrme,
  input  logic [7:0]      rxovre,
  output logic [7:0]      rxclr,
  input  logic            rbufREAD,
  output logic [RB_W-1:0] rbufDATA,
  output logic            rdone,
  output logic            sa,
  input  logic            saclr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALARM + 1);

  scan_state_e     state_q, state_d;
  logic [2:0]      line_q, line_d;
  logic            ovrpend_q, ovrpend_d;
  logic [CW-1:0]   acnt_q, acnt_d;
  logic            sa_q, sa_d;

  logic            reset_all;
  logic            capture, pop_eff, wr_en;
  logic [RB_W-1:0] entry, silo_head;
  logic            silo_empty, silo_full;
  logic [AW:0]     silo_count;

  assign reset_all = rst | clr;
  // Capture is suppressed while reset/clear is asserted so no flag is cleared for a lost char.
  assign capture   = (state_q == SCAN) & scen & rxfull[line_q] & ~reset_all;
  assign pop_eff   = rbufREAD & ~silo_empty;
  assign wr_en     = capture & (~silo_full | pop_eff);
  assign entry     = rbuf_pack(rxovre[line_q] | ovrpend_q, rxfrme[line_q], rxpare[line_q],
                               line_q, rxdata[{line_q, 3'b000} +: 8]);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    rxclr   = 8'h00;
    case (state_q)
      SCAN: begin
        if (capture) begin
          rxclr   = 8'h01 << line_q;
          state_d = HOLD;
        end else if (scen) begin
          line_d = line_q + 3'd1;
        end
      end
      HOLD: begin
        state_d = SCAN;
        line_d  = line_q + 3'd1;
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    ovrpend_d = ovrpend_q;
    if (wr_en)        ovrpend_d = 1'b0;
    else if (capture) ovrpend_d = 1'b1;

    acnt_d = acnt_q;
    sa_d   = sa_q;
    if (saclr) begin
      acnt_d = '0;
      sa_d   = 1'b0;
    end else if (wr_en && acnt_q != CW'(ALARM)) begin
      acnt_d = acnt_q + 1'b1;
      if (acnt_q == CW'(ALARM - 1)) sa_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      state_q   <= SCAN;
      line_q    <= 3'd0;
      ovrpend_q <= 1'b0;
      acnt_q    <= '0;
      sa_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      ovrpend_q <= ovrpend_d;
      acnt_q    <= acnt_d;
      sa_q      <= sa_d;
    end
  end

  dz_silo_fifo #(
    .DATA_W (RB_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset_all),
    .push  (wr_en),
    .pop   (pop_eff),
    .din   (entry),
    .head  (silo_head),
    .empty (silo_empty),
    .full  (silo_full),
    .count (silo_count)
  );

  assign rdone    = (silo_count != '0);
  assign rbufDATA = silo_empty ? '0 : silo_head;
  assign sa       = sa_q;

endmodule
